// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-cycle byte/half/word data memory with post-reset clear sequence
module data_mem_ctrl #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] clr_idx;
  logic [31:0] mem [DEPTH];
  logic [31:0] widx, word, wdata, load;
  logic [15:0] shifted;
  logic [1:0] lane;
  logic [3:0] be;
  logic err, accept;
  always_comb begin
    widx = 32'(req_addr[ADDR_W-1:2]);
    lane = req_addr[1:0];
    err = req_size == 2'b11 || (req_size == 2'b01 && lane[0]) ||
          (req_size == 2'b10 && lane != 2'b00) || widx >= 32'(DEPTH);
    busy = !RST && state == CLEAR;
    req_ready = !RST && state == RUN;
    accept = req_valid && req_ready;
    word = mem[widx[IW-1:0]];
    shifted = 16'(word >> {lane, 3'b000});
    load = req_size == 2'b00 ? {{24{!req_unsigned && shifted[7]}}, shifted[7:0]} :
           req_size == 2'b01 ? {{16{!req_unsigned && shifted[15]}}, shifted} : word;
    wdata = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
            req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    be = req_size == 2'b00 ? 4'b0001 << lane :
         req_size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    state_nx = (state == CLEAR && clr_idx == IW'(DEPTH - 1)) ? RUN : state;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      clr_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err <= err;
        rsp_rdata <= (err || req_we) ? '0 : load;
      end
    end
  end
  // Reading the array combinationally at acceptance gives read-after-write for free.
  always_ff @(posedge CLK) begin
    if (!RST && state == CLEAR) mem[clr_idx] <= '0;
    else if (accept && req_we && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx[IW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed + random checks against a byte-addressed reference memory
module tb_data_mem_ctrl;
  localparam int DEPTH = 256, AW = 12;
  logic CLK = 0, RST = 1, req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [AW-1:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .CLEAR_ON_RESET(1)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );
  always #5 CLK = ~CLK;
  int total = 0, bad = 0;
  logic [7:0] ref_mem [4*DEPTH];
  int cnt = 0;
  bit armed = 0;
  logic exp_v = 0, exp_err = 0;
  logic [31:0] exp_rd = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_req();
    int n = 1 << req_size;
    int a = int'(req_addr);
    logic [31:0] v = 0;
    exp_err = req_size == 2'b11 || (a % n) != 0 || a >= 4 * DEPTH;
    if (exp_err) exp_rd = 0;
    else if (req_we) begin
      for (int i = 0; i < n; i++) ref_mem[a+i] = req_wdata[8*i +: 8];
      exp_rd = 0;
    end else begin
      for (int i = 0; i < n; i++) v |= 32'(ref_mem[a+i]) << (8 * i);
      if (!req_unsigned && n < 4 && v[8*n-1]) v |= 32'hFFFFFFFF << (8 * n);
      exp_rd = v;
    end
  endtask
  initial forever begin
    @(posedge CLK);
    if (RST) begin
      armed = 1; cnt = DEPTH; exp_v = 0; exp_rd = 0; exp_err = 0;
    end else if (armed && cnt > 0) begin
      cnt--;
      exp_v = 0;
      if (cnt == 0) foreach (ref_mem[i]) ref_mem[i] = 0;
    end else if (armed) begin
      exp_v = req_valid;
      if (req_valid) model_req();
    end
  end
  initial forever begin
    @(negedge CLK);
    if (armed) begin
      check("busy", busy, !RST && cnt > 0);
      check("ready", req_ready, !RST && cnt == 0);
      check("rsp_valid", rsp_valid, exp_v);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", rsp_err, exp_err);
    end
  end
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [AW-1:0] addr, input logic [31:0] wd);
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    tick();
  endtask
  task automatic idle();
    req_valid = 0;
    tick();
  endtask
  task automatic wait_clear(output int n);
    n = 0;
    while (busy && n < 1000) begin
      check("busy_no_rsp", rsp_valid, 0);
      n++;
      tick();
    end
  endtask
  initial begin
    int n;
    RST = 1;
    repeat (3) tick();
    RST = 0;
    #1;
    req_valid = 1; req_we = 1; req_size = 2; req_addr = 'h3FC; req_wdata = '1;
    wait_clear(n);
    check("clr_len", n, DEPTH);
    send(0, 2, 0, 'h3FC, 0);
    check("clr_v", rsp_valid, 1);
    check("clr_rd", rsp_rdata, 0);
    check("clr_err", rsp_err, 0);
    send(1, 0, 0, 'h40, 'h11);
    send(1, 0, 0, 'h41, 'h22);
    send(1, 0, 0, 'h42, 'h33);
    send(1, 0, 0, 'h43, 'h84);
    check("st_rd", rsp_rdata, 0);
    send(0, 2, 0, 'h40, 0);
    check("w40", rsp_rdata, 32'h84332211);
    send(0, 0, 0, 'h43, 0);
    check("sb43", rsp_rdata, 32'hFFFFFF84);
    send(0, 0, 1, 'h43, 0);
    check("ub43", rsp_rdata, 32'h00000084);
    send(1, 2, 0, 'h80, 32'hDEADBEEF);
    send(1, 1, 0, 'h82, 32'h00001234);
    send(0, 2, 0, 'h80, 0);
    check("raw_w80", rsp_rdata, 32'h1234BEEF);
    send(0, 1, 0, 'h80, 0);
    check("sh80", rsp_rdata, 32'hFFFFBEEF);
    send(1, 2, 0, 'h81, 0);
    check("mis_st_err", rsp_err, 1);
    send(0, 2, 0, 'h80, 0);
    check("mis_st_keep", rsp_rdata, 32'h1234BEEF);
    check("ok_err", rsp_err, 0);
    send(0, 1, 0, 'h03, 0);
    check("mis_h_err", rsp_err, 1);
    check("mis_h_rd", rsp_rdata, 0);
    send(0, 2, 0, 'h400, 0);
    check("oob_err", rsp_err, 1);
    send(0, 3, 0, 'h40, 0);
    check("sz3_err", rsp_err, 1);
    for (int i = 0; i < 8; i++) send(1, 2, 0, AW'('h100 + 4 * i), 32'h01010101 * i + 32'h80000000);
    for (int i = 0; i < 8; i++) begin
      send(0, 2, 0, AW'('h100 + 4 * i), 0);
      check("b2b_v", rsp_valid, 1);
      check("b2b_rd", rsp_rdata, 32'h01010101 * i + 32'h80000000);
    end
    idle();
    check("b2b_end", rsp_valid, 0);
    send(1, 2, 0, 'h200, 32'hCAFEF00D);
    idle();
    RST = 1;
    tick();
    RST = 0;
    repeat (100) tick();
    RST = 1;
    tick();
    RST = 0;
    #1;
    req_valid = 1; req_we = 1; req_size = 2; req_addr = 'h204; req_wdata = '1;
    wait_clear(n);
    check("reclr_len", n, DEPTH);
    send(0, 2, 0, 'h200, 0);
    check("reclr_rd", rsp_rdata, 0);
    send(0, 2, 0, 'h204, 0);
    check("busy_wr_drop", rsp_rdata, 0);
    repeat (600) begin
      req_valid = $urandom_range(0, 4) != 0;
      req_we = 1'($urandom_range(0, 1));
      req_size = $urandom_range(0, 9) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
      req_unsigned = 1'($urandom_range(0, 1));
      req_addr = $urandom_range(0, 7) == 0 ? AW'($urandom_range(0, 4095)) : AW'($urandom_range(0, 63));
      req_wdata = $urandom;
      tick();
    end
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
